bm_if_arbiter: RTL and testbench
================================

BM_IF_ARBITER -- requirements
Module: bm_if_arbiter

Interface
REQ-001 Parameter: BITS, default 2, operand and result width.
REQ-002 The block SHALL provide these ports, one per line (name, direction, width, meaning):
- clock  input  1  single clock, all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- req0  input  1  requester 0 request, level
- req1  input  1  requester 1 request, level
- a0, b0  input  BITS  requester 0 operands
- c0, d0  input  1  requester 0 control bits
- a1, b1  input  BITS  requester 1 operands
- c1, d1  input  1  requester 1 control bits
- gnt0, gnt1  output  1  grant, registered, one-hot or zero
- done0, done1  output  1  completion pulse, one cycle
- res0, res1  output  BITS  per-requester result registers
- busy  output  1  high whenever the FSM is not in IDLE
- txn_cnt  output  4  completed-transaction counter

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, GRANT, EXEC, RESP.
REQ-004 IDLE SHALL go to GRANT when (req0|req1) is high at a clock edge, and SHALL remain in IDLE otherwise.
REQ-005 On the IDLE->GRANT edge, the winner SHALL be chosen and its a/b/c/d SHALL be latched into internal operand registers.
REQ-006 Winner selection SHALL work as follows:
- only one request high -> that requester wins
- both high -> the requester not served last wins
- the last-served pointer resets to 1, so requester 0 wins the first contention
REQ-007 GRANT SHALL go to EXEC unconditionally; EXEC SHALL go to RESP unconditionally; RESP SHALL go to IDLE unconditionally.
REQ-008 gntN SHALL be high during the GRANT, EXEC and RESP states for the winner only; both grants SHALL be low in IDLE.
REQ-009 On the EXEC->RESP edge, the winner's result register SHALL update from the latched operands:
- c==0 -> result = 0
- c==1, d==1 -> result = a & b (bitwise)
- c==1, d==0 -> result holds its previous value
REQ-010 doneN SHALL be high for exactly the RESP cycle of the winner; resN SHALL be valid in that cycle and SHALL hold until that requester's next completion.
REQ-011 The non-winning result register SHALL never change during a transaction.
REQ-012 Latency: a request sampled at edge k SHALL produce gnt high after edge k and done high after edge k+2; done SHALL drop after edge k+3.
REQ-013 Back-to-back behaviour: the earliest next grant SHALL be on the edge that leaves RESP+1; one IDLE cycle SHALL always separate transactions.
REQ-014 A request deasserted mid-transaction SHALL be ignored; the transaction SHALL complete.
REQ-015 Request or operand changes after the latch edge SHALL NOT affect the in-flight result.
REQ-016 The last-served pointer SHALL update on the IDLE->GRANT edge.
REQ-017 txn_cnt SHALL increment by 1 on each RESP->IDLE edge, modulo 16 (15 -> 0 wraps silently).
REQ-018 busy SHALL be high in GRANT, EXEC and RESP, and low in IDLE.

Reset
REQ-019 While reset is high, regardless of clock, the block SHALL hold:
- state = IDLE
- gnt0 = gnt1 = 0, done0 = done1 = 0, busy = 0
- res0 = res1 = 0, txn_cnt = 0
- last-served pointer = 1
REQ-020 Reset asserted mid-transaction SHALL abort it with no done pulse, no result update and no txn_cnt increment.
REQ-021 After reset deasserts, the first clock edge SHALL sample requests normally.

Verification
REQ-022 Single request: req0=1, a0=2'b11, b0=2'b10, c0=1, d0=1 at edge 1 -> gnt0 high after edge 1, done0 pulse after edge 3, res0=2'b10, res1 unchanged at 0, txn_cnt=1.
REQ-023 Contention: req0=req1=1 held after reset -> grants alternate 0,1,0,1 with one IDLE cycle between transactions; done0/done1 pulses alternate.
REQ-024 Hold/clear: prime res1=2'b01, then issue c1=1, d1=0 -> res1 stays 2'b01; then issue c1=0 -> res1=2'b00.
REQ-025 Mid-flight changes: drop req0 and change a0 during EXEC -> transaction completes with the originally latched operands; done0 still pulses.
REQ-026 Reset abort: assert reset during EXEC -> all outputs go to 0 immediately (asynchronously); no done pulse; next contention grants requester 0.
REQ-027 Counter wrap: run 16 transactions -> txn_cnt returns to 0; the 17th transaction yields txn_cnt=1.

Source files
------------

// File: rtl/bm_if_arbiter_if.sv
// bm_if_arbiter_if: request/operand/result bundle between two requesters and the arbiter
//   master: drives req0/1, a0/1, b0/1, c0/1, d0/1; sees grants, done pulses, results, busy, txn_cnt
//   slave : the arbiter side of the same signals
interface bm_if_arbiter_if #(parameter int BITS = 2);
    logic            req0, req1;
    logic [BITS-1:0] a0, b0, a1, b1;
    logic            c0, d0, c1, d1;
    logic            gnt0, gnt1, done0, done1, busy;
    logic [BITS-1:0] res0, res1;
    logic [3:0]      txn_cnt;
    modport master (
        output req0, req1, a0, b0, c0, d0, a1, b1, c1, d1,
        input  gnt0, gnt1, done0, done1, res0, res1, busy, txn_cnt
    );
    modport slave (
        input  req0, req1, a0, b0, c0, d0, a1, b1, c1, d1,
        output gnt0, gnt1, done0, done1, res0, res1, busy, txn_cnt
    );
endinterface

// File: rtl/bm_if_arbiter.sv
// bm_if_arbiter: two-requester round-robin arbiter running a 4-state IDLE/GRANT/EXEC/RESP transaction
//   clock : posedge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of bm_if_arbiter_if (requests/operands in; grants, done, results, busy, txn_cnt out)
module bm_if_arbiter #(parameter int BITS = 2) (
    input logic            clock,
    input logic            reset,
    bm_if_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, GRANT = 2'd1, EXEC = 2'd2, RESP = 2'd3;
    logic [1:0]      state_q, state_d;
    logic            last_q, last_d;
    logic [BITS-1:0] a_q, a_d, b_q, b_d, res0_q, res0_d, res1_q, res1_d, res_new;
    logic            c_q, c_d, d_q, d_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            start, sel, upd;
    // last_q doubles as the current winner: it is rewritten on every IDLE->GRANT edge
    always_comb begin
        start   = state_q == IDLE && (bus.req0 || bus.req1);
        sel     = (bus.req0 && bus.req1) ? !last_q : bus.req1;
        state_d = state_q == IDLE ? (start ? GRANT : IDLE) : state_q + 2'd1;
        last_d  = start ? sel : last_q;
        a_d     = start ? (sel ? bus.a1 : bus.a0) : a_q;
        b_d     = start ? (sel ? bus.b1 : bus.b0) : b_q;
        c_d     = start ? (sel ? bus.c1 : bus.c0) : c_q;
        d_d     = start ? (sel ? bus.d1 : bus.d0) : d_q;
        upd     = state_q == EXEC;
        res_new = !c_q ? '0 : d_q ? (a_q & b_q) : (last_q ? res1_q : res0_q);
        res0_d  = (upd && !last_q) ? res_new : res0_q;
        res1_d  = (upd && last_q) ? res_new : res1_q;
        cnt_d   = cnt_q + {3'd0, state_q == RESP};
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            d_q     <= 1'b0;
            res0_q  <= '0;
            res1_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            d_q     <= d_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            cnt_q   <= cnt_d;
        end
    end
    assign bus.busy    = state_q != IDLE;
    assign bus.gnt0    = bus.busy && !last_q;
    assign bus.gnt1    = bus.busy && last_q;
    assign bus.done0   = state_q == RESP && !last_q;
    assign bus.done1   = state_q == RESP && last_q;
    assign bus.res0    = res0_q;
    assign bus.res1    = res1_q;
    assign bus.txn_cnt = cnt_q;
endmodule

// File: tb/tb_bm_if_arbiter.sv
// tb_bm_if_arbiter: table-driven, hand-sequenced and randomized checks of bm_if_arbiter against a transaction-level model
module tb_bm_if_arbiter;
    typedef struct {
        bit r0, r1;
        logic [1:0] a0, b0;
        bit c0, d0;
        logic [1:0] a1, b1;
        bit c1, d1;
        bit ew;
        logic [1:0] er;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int errors = 0;
    int checks = 0;
    logic [1:0] m_res [2];
    bit m_last;
    int m_cnt;
    bit obs_win;
    vec_t v [11];

    bm_if_arbiter_if #(.BITS(2)) bus ();
    bm_if_arbiter #(.BITS(2)) dut (.clock(clock), .reset(reset), .bus(bus));

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_gnt"}, {bus.gnt1, bus.gnt0}, 0);
        chk({nm, "_done"}, {bus.done1, bus.done0}, 0);
        chk({nm, "_busy"}, bus.busy, 0);
        chk({nm, "_res0"}, bus.res0, 0);
        chk({nm, "_res1"}, bus.res1, 0);
        chk({nm, "_cnt"}, bus.txn_cnt, 0);
    endtask

    function automatic vec_t mkv(input int r0, r1, a0, b0, c0, d0, a1, b1, c1, d1, ew, er);
        vec_t t;
        t.r0 = r0[0]; t.r1 = r1[0];
        t.a0 = a0[1:0]; t.b0 = b0[1:0]; t.c0 = c0[0]; t.d0 = d0[0];
        t.a1 = a1[1:0]; t.b1 = b1[1:0]; t.c1 = c1[0]; t.d1 = d1[0];
        t.ew = ew[0]; t.er = er[1:0];
        return t;
    endfunction

    function automatic logic [1:0] rule(input bit c, d, input logic [1:0] a, b, old);
        return !c ? 2'd0 : d ? (a & b) : old;
    endfunction

    // Entered at a negedge with the DUT idle; leaves at the negedge after returning to IDLE.
    task automatic do_txn(input bit r0, r1, input logic [1:0] a0, b0, input bit c0, d0,
                          input logic [1:0] a1, b1, input bit c1, d1, input bit scr);
        bit w;
        logic [1:0] e0, e1;
        w = (r0 && r1) ? !m_last : r1;
        m_last = w;
        e0 = m_res[0];
        e1 = m_res[1];
        if (w) e1 = rule(c1, d1, a1, b1, e1);
        else e0 = rule(c0, d0, a0, b0, e0);
        bus.req0 = r0; bus.req1 = r1;
        bus.a0 = a0; bus.b0 = b0; bus.c0 = c0; bus.d0 = d0;
        bus.a1 = a1; bus.b1 = b1; bus.c1 = c1; bus.d1 = d1;
        @(posedge clock); @(negedge clock);
        obs_win = bus.gnt1;
        chk("grant_gnt", {bus.gnt1, bus.gnt0}, w ? 2 : 1);
        chk("grant_busy", bus.busy, 1);
        chk("grant_done", {bus.done1, bus.done0}, 0);
        if (scr) begin
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            bus.a0 = ~a0; bus.b0 = ~b0; bus.c0 = !c0; bus.d0 = !d0;
            bus.a1 = ~a1; bus.b1 = ~b1; bus.c1 = !c1; bus.d1 = !d1;
        end
        @(posedge clock); @(negedge clock);
        chk("exec_gnt", {bus.gnt1, bus.gnt0}, w ? 2 : 1);
        chk("exec_done", {bus.done1, bus.done0}, 0);
        chk("exec_res0", bus.res0, m_res[0]);
        chk("exec_res1", bus.res1, m_res[1]);
        @(posedge clock); @(negedge clock);
        chk("resp_gnt", {bus.gnt1, bus.gnt0}, w ? 2 : 1);
        chk("resp_done", {bus.done1, bus.done0}, w ? 2 : 1);
        chk("resp_busy", bus.busy, 1);
        chk("resp_res0", bus.res0, e0);
        chk("resp_res1", bus.res1, e1);
        m_res[0] = e0;
        m_res[1] = e1;
        m_cnt = (m_cnt + 1) % 16;
        @(posedge clock); @(negedge clock);
        chk("idle_busy", bus.busy, 0);
        chk("idle_gnt", {bus.gnt1, bus.gnt0}, 0);
        chk("idle_done", {bus.done1, bus.done0}, 0);
        chk("idle_cnt", bus.txn_cnt, m_cnt);
    endtask

    task automatic model_reset();
        m_res[0] = 2'd0;
        m_res[1] = 2'd0;
        m_last = 1'b1;
        m_cnt = 0;
    endtask

    task automatic rand_txn();
        int rr;
        rr = $urandom_range(1, 3);
        do_txn(rr[0], rr[1], 2'($urandom_range(3)), 2'($urandom_range(3)), 1'($urandom_range(1)),
               1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
               1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
    endtask

    initial begin
        v[0]  = mkv(1, 0, 3, 2, 1, 1, 0, 0, 0, 0, 0, 2);
        v[1]  = mkv(1, 1, 1, 3, 1, 1, 3, 1, 1, 1, 1, 1);
        v[2]  = mkv(1, 1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        v[3]  = mkv(1, 1, 0, 0, 0, 0, 3, 3, 1, 0, 1, 1);
        v[4]  = mkv(0, 1, 0, 0, 0, 0, 3, 3, 0, 1, 1, 0);
        v[5]  = mkv(0, 1, 0, 0, 0, 0, 2, 3, 1, 1, 1, 2);
        v[6]  = mkv(1, 1, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0);
        v[7]  = mkv(1, 0, 2, 2, 1, 1, 0, 0, 0, 0, 0, 2);
        v[8]  = mkv(0, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1);
        v[9]  = mkv(0, 1, 0, 0, 0, 0, 3, 3, 1, 0, 1, 1);
        v[10] = mkv(0, 1, 0, 0, 0, 0, 3, 3, 0, 0, 1, 0);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.c0 = 1'b0; bus.d0 = 1'b0;
        bus.a1 = '0; bus.b1 = '0; bus.c1 = 1'b0; bus.d1 = 1'b0;
        model_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_zero("reset");
        reset = 1'b0;

        foreach (v[i]) begin
            do_txn(v[i].r0, v[i].r1, v[i].a0, v[i].b0, v[i].c0, v[i].d0,
                   v[i].a1, v[i].b1, v[i].c1, v[i].d1, 1'b0);
            chk("tbl_win", obs_win, v[i].ew);
            chk("tbl_res", v[i].ew ? bus.res1 : bus.res0, v[i].er);
        end

        do_txn(1, 0, 2'd3, 2'd1, 1, 1, 2'd0, 2'd0, 0, 0, 1'b1);
        chk("midflight_res0", bus.res0, 1);

        bus.req0 = 1'b1; bus.req1 = 1'b0;
        bus.a0 = 2'd3; bus.b0 = 2'd2; bus.c0 = 1'b1; bus.d0 = 1'b1;
        @(posedge clock); @(negedge clock);
        @(posedge clock); @(negedge clock);
        chk("abort_busy", bus.busy, 1);
        bus.req0 = 1'b0;
        #2 reset = 1'b1;
        #1 chk_zero("abort_async");
        @(posedge clock); @(negedge clock);
        chk_zero("abort_hold");
        @(posedge clock); @(negedge clock);
        chk_zero("abort_nodone");
        reset = 1'b0;
        model_reset();

        for (int i = 0; i < 4; i++) begin
            do_txn(1, 1, 2'($urandom_range(3)), 2'($urandom_range(3)), 1, 1,
                   2'($urandom_range(3)), 2'($urandom_range(3)), 1, 1, 1'b0);
            chk("alt_win", obs_win, i % 2);
        end
        for (int i = 0; i < 12; i++) rand_txn();
        chk("wrap_zero", bus.txn_cnt, 0);
        rand_txn();
        chk("wrap_one", bus.txn_cnt, 1);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(2) == 0) begin
                bus.req0 = 1'b0; bus.req1 = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clock);
                chk("gap_busy", bus.busy, 0);
            end
            rand_txn();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
